// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             valid
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state  | meaning
    // S_IDLE | ready=1, waiting for start
    // S_SHIFT| one operand bit processed per cycle, counter 0..WIDTH-1
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [WIDTH-1:0] diff_q;
    logic             br_q, br_d;
    logic             bout_q, valid_q;
    logic             d_bit, last_bit, accept;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
    end

    assign accept   = ready && start;
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST);

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign d_bit = a_q[0] ^ b_q[0] ^ br_q;
    assign br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_d = {d_bit, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                br_q  <= bin;
                cnt_q <= '0;
                res_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
`endif
            end else if (state_q == S_SHIFT) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                br_q  <= br_d;
                res_q <= res_d;
                cnt_q <= cnt_q + CW'(1);
                if (last_bit) begin
                    diff_q  <= res_d;
                    bout_q  <= br_d;
                    valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // d_bit is the result MSB on the final edge.
                    ovf_q <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
                end
            end
        end
    end

    assign diff  = diff_q;
    assign bout  = bout_q;
    assign valid = valid_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule
